// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths and the interconnect FSM state encoding.
package apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t ST_IDLE   = 2'd0;
  localparam apb_state_t ST_SETUP  = 2'd1;
  localparam apb_state_t ST_ACCESS = 2'd2;

endpackage

// File: rtl/apb_slave_mux_if.sv
// APB3 bus bundle between the bridge master port and NSLV peripheral slaves.
interface apb_slave_mux_if
  import apb_pkg::*;
#(
  parameter int NSLV = 4
);

  logic                     PSEL;
  logic                     PENABLE;
  logic [APB_AW-1:0]        PADDR;
  logic                     PREADY;
  logic [APB_DW-1:0]        PRDATA;
  logic                     PSLVERR;
  logic [NSLV-1:0]          PSELx;
  logic [NSLV-1:0]          PREADYx;
  logic [APB_DW*NSLV-1:0]   PRDATAx;
  logic [NSLV-1:0]          PSLVERRx;

  // The interconnect is the slave of the bridge and the master of the peripherals.
  modport slave (
    input  PSEL, PENABLE, PADDR, PREADYx, PRDATAx, PSLVERRx,
    output PREADY, PRDATA, PSLVERR, PSELx
  );

  modport master (
    output PSEL, PENABLE, PADDR, PREADYx, PRDATAx, PSLVERRx,
    input  PREADY, PRDATA, PSLVERR, PSELx
  );

endinterface

// File: rtl/apb_range_dec.sv
// Combinational address decoder: NSLV equal, contiguous windows starting at BASE_ADDR.
module apb_range_dec
  import apb_pkg::*;
#(
  parameter int          NSLV        = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
  parameter logic [31:0] REGION_SIZE = 32'h0000_1000
) (
  input  logic [APB_AW-1:0] paddr,
  output logic [NSLV-1:0]   hit_vec,
  output logic              hit
);

  logic [63:0] paddr_w;

  assign paddr_w = {32'd0, paddr};

  // Bounds are computed in 64 bits so the top window never wraps past 2^32.
  for (genvar i = 0; i < NSLV; i++) begin : g_win
    localparam logic [63:0] LO = 64'(BASE_ADDR) + 64'(i) * 64'(REGION_SIZE);
    localparam logic [63:0] HI = LO + 64'(REGION_SIZE);
    assign hit_vec[i] = (paddr_w >= LO) && (paddr_w < HI);
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/apb_slave_mux.sv
// APB3 interconnect: address decode, one-hot select, response mux and default error slave.
// Define APB_TIMEOUT_EN to terminate hung ACCESS phases after TIMEOUT_CYCLES.
module apb_slave_mux
  import apb_pkg::*;
#(
  parameter int          NSLV           = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0200,
  parameter logic [31:0] REGION_SIZE    = 32'h0000_1000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  apb_slave_mux_if.slave bus,
  output logic           dec_err,
  output logic           tmo_err
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  if (NSLV < 1 || NSLV > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_slave_mux: parameter out of range");
  end

  apb_state_t      state_q, state_d, phase;
  logic [NSLV-1:0] hit_vec;
  logic            hit;
  logic [IW-1:0]   idx_dec, idx_q, idx_d;
  logic            hit_q, hit_d;
  logic            dec_err_q, dec_err_d;
  logic            tmo_now, timeout_now;
  logic [NSLV-1:0] psel_x;
  logic            pready, pslverr;
  logic [APB_DW-1:0] prdata;

  apb_range_dec #(
    .NSLV        (NSLV),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_SIZE (REGION_SIZE)
  ) u_dec (
    .paddr   (bus.PADDR),
    .hit_vec (hit_vec),
    .hit     (hit)
  );

  always_comb begin
    idx_dec = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (hit_vec[i]) idx_dec = IW'(i);
    end
  end

  // The register only ever remembers an ACCESS in progress; the SETUP phase is
  // recognised in the same cycle the master presents it, giving zero decode latency.
  always_comb begin
    phase = ST_IDLE;
    if (PRESETn && bus.PSEL) begin
      if (state_q == ST_ACCESS)  phase = ST_ACCESS;
      else if (!bus.PENABLE)     phase = ST_SETUP;
    end
  end

  always_comb begin
    psel_x  = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    tmo_now = 1'b0;
    case (phase)
      ST_SETUP: psel_x = hit_vec;
      ST_ACCESS: begin
        if (hit_q) begin
          psel_x[idx_q] = 1'b1;
          pready        = bus.PREADYx[idx_q];
          pslverr       = bus.PSLVERRx[idx_q];
          prdata        = bus.PRDATAx[int'(idx_q)*APB_DW +: APB_DW];
          if (!bus.PREADYx[idx_q] && timeout_now) begin
            pready  = 1'b1;
            pslverr = 1'b1;
            tmo_now = 1'b1;
          end
        end else begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = ST_IDLE;
    hit_d     = hit_q;
    idx_d     = idx_q;
    dec_err_d = (phase == ST_ACCESS) && !hit_q;
    if (phase == ST_SETUP) begin
      state_d = ST_ACCESS;
      hit_d   = hit;
      idx_d   = idx_dec;
    end else if (phase == ST_ACCESS && !pready) begin
      state_d = ST_ACCESS;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      dec_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      dec_err_q <= dec_err_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_err_q, tmo_err_d;

  // Counts ACCESS cycles already spent; zero in the first ACCESS cycle.
  always_comb begin
    cnt_d     = (phase == ST_ACCESS) ? cnt_q + CW'(1) : '0;
    tmo_err_d = tmo_now;
  end

  assign timeout_now = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign tmo_err = tmo_err_q;
`else
  assign timeout_now = 1'b0;
  assign tmo_err     = 1'b0;
`endif

  assign bus.PSELx   = psel_x;
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pslverr;
  assign bus.PRDATA  = prdata;
  assign dec_err     = dec_err_q;

endmodule

// File: doc/apb_slave_mux.md
# apb_slave_mux

Parametrised APB3 interconnect between the single APB master port of the SoC bus bridge and up to NSLV peripheral slaves. It decodes PADDR into one of NSLV equal-sized, contiguous windows and drives a one-hot slave select. It tracks the APB SETUP/ACCESS phases and routes PREADY/PRDATA/PSLVERR back from the selected slave. Unmapped accesses are answered by an internal default slave with an error, and, when enabled, hung slaves are terminated by a timeout.

## Interface
Parameters:
- NSLV, 4, number of slave windows (1..16)
- BASE_ADDR, 32'h0000_0200, first byte of window 0
- REGION_SIZE, 32'h0000_1000, bytes per window (power of two)
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles before forced termination (used only with APB_TIMEOUT_EN)

Ports:
- PCLK  in  1  clock; one clock domain, everything on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- PSEL  in  1  master select
- PENABLE  in  1  master access phase
- PADDR  in  32  master address
- PREADY  out  1  transfer complete to master
- PRDATA  out  32  read data to master
- PSLVERR  out  1  error to master, valid when PREADY=1
- PSELx  out  NSLV  one-hot slave selects
- PREADYx  in  NSLV  slave ready, bit i from slave i
- PRDATAx  in  32*NSLV  slave read data, slave i at [32i+31:32i]
- PSLVERRx  in  NSLV  slave error
- dec_err  out  1  one-cycle pulse when an unmapped transfer completes
- tmo_err  out  1  one-cycle pulse when a timeout terminates a transfer (tied 0 without macro)

## Operation
- Window i spans BASE_ADDR + i*REGION_SIZE to BASE_ADDR + (i+1)*REGION_SIZE - 1. The comparison is unsigned 32-bit and uses no wrap: an address below BASE_ADDR, or at or above BASE_ADDR + NSLV*REGION_SIZE, is unmapped.
- FSM states are IDLE, SETUP and ACCESS.
  - IDLE→SETUP on PSEL=1, PENABLE=0.
  - SETUP→ACCESS unconditionally on the next edge.
  - ACCESS→SETUP when the transfer completes and the master presents PSEL=1, PENABLE=0 (back-to-back).
  - ACCESS→IDLE when the transfer completes otherwise.
  - Any state→IDLE when PSEL=0. This aborts the transfer, and PSELx drops that same cycle.
- In SETUP, PSELx is decoded combinationally from PADDR. The decoded index and hit flag are registered at the SETUP→ACCESS edge.
- In ACCESS, PSELx is driven from the registered index. PREADY, PRDATA and PSLVERR are muxed combinationally from that slave.
- Default slave (no hit): PSELx stays all-zero. In the first ACCESS cycle it returns PREADY=1, PSLVERR=1, PRDATA=0, and dec_err pulses.
- Outside ACCESS: PREADY=0, PSLVERR=0, PRDATA=0.
- Reset values: state IDLE, PSELx=0, PREADY=0, PRDATA=0, PSLVERR=0, dec_err=0, tmo_err=0, registered index 0, timeout counter 0.
- Reset asserted mid-transfer: all outputs return to reset values immediately, asynchronously.

## Timing
- Decode latency is zero: PSELx is valid in the same cycle as the SETUP-phase PADDR.
- Response path is combinational, so PREADY reaches the master in the same cycle as PREADYx.
- A minimum transfer takes 2 cycles (SETUP plus one ACCESS). Wait states are inserted while the selected PREADYx is 0.
- dec_err and tmo_err are registered. Each is high for the one cycle after the terminating ACCESS cycle.

## Configuration
- APB_TIMEOUT_EN defined:
  - An ACCESS-cycle counter clears on entering ACCESS.
  - When it reaches TIMEOUT_CYCLES-1 with the selected PREADYx still 0, the block forces PREADY=1 and PSLVERR=1 to the master and pulses tmo_err.
  - PSELx deasserts on the next edge.
  - If the slave's PREADYx and the timeout coincide, the slave response wins and no tmo_err is raised.
- APB_TIMEOUT_EN undefined: no counter is built, ACCESS waits indefinitely, and tmo_err is constant 0.

## Structure
- Shared package apb_pkg holds the FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2) and the APB address/data width constants (32).
- Sub-module apb_range_dec is purely combinational: PADDR in, one-hot hit vector and hit flag out. It is generated over NSLV and shared with future bridges.

## Test plan
- NSLV=4 defaults, read at PADDR=0x0200, slave 0 PREADYx immediate → PSELx=0001 in SETUP, PREADY=1 on cycle 2, PRDATA=slave 0 data.
- PADDR=0x11FF then 0x1200 → PSELx=0001, then 0010 (boundary between window 0 and window 1).
- PADDR=0x01FC and PADDR=0x4200 → PSELx=0000, PREADY=1 and PSLVERR=1 in the first ACCESS cycle, dec_err pulses once.
- Slave 2 holds PREADYx=0 for 3 cycles, then 1 with PSLVERRx=1 → 3 wait states, PSLVERR=1 passed through; a back-to-back next SETUP re-decodes correctly.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave 3 never ready → PREADY=1 and PSLVERR=1 on the 8th ACCESS cycle, tmo_err pulses, PSELx=0000 the next cycle.
- PRESETn pulled low during ACCESS of slave 1 → PSELx=0 and PREADY=0 immediately, state IDLE after release; PSEL dropped mid-ACCESS → IDLE with no error pulse.
